muldiv_sequencer: RTL and testbench

- Multi-cycle controller for RV64M multiply/divide in the EX stage, beside the single-cycle ALU.
- Accepts one M-extension op from the decoder, stalls the pipeline and iterates a radix-2 shift-add multiplier / restoring divider.
- Applies RISC-V sign, word (W) and corner-case rules, then returns the result for one cycle.

---
 rtl/muldiv_sequencer_pkg.sv | 23 ++
 rtl/muldiv_iter.sv | 41 ++++
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared definitions for the RV64M multiply/divide sequencer.
//   - func3 encodings of the M-extension ops
//   - FSM state encoding (3 bits)
package muldiv_sequencer_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational radix-2 iteration step.
//   acc      in  2*XLEN  multiply: {partial hi, multiplier/product lo}
//                        divide:   {remainder, dividend/quotient}
//   opnd     in  XLEN    multiplicand (mul) or divisor (div)
//   div_mode in  1       0 = add-then-shift multiply, 1 = restoring divide
//   acc_nxt  out 2*XLEN  accumulator after this step
//   qbit     out 1       quotient bit produced (0 in multiply mode)
module muldiv_iter
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              qbit
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            ge;

  always_comb begin
    // multiply: add multiplicand into the high half when the multiplier lsb is set,
    // then shift the whole accumulator right (carry lands in the top bit)
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // divide: remainder shifted left with the next dividend bit; it can need
    // XLEN+1 bits, but after a successful subtract it always fits in XLEN
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    ge      = (rem_sh >= {1'b0, opnd});
    rem_sub = rem_sh[XLEN-1:0] - opnd;
    qbit    = div_mode & ge;
    if (div_mode)
      acc_nxt = {(ge ? rem_sub : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
    else
      acc_nxt = {sum, acc[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV64M multiply/divide controller for EX.
//   clk, rst        clock (rising edge), async active-high reset
//   start           M-op valid in EX (sampled only in IDLE/DONE)
//   func3, word     op select, 1 = W variant
//   src1, src2      operands, latched at acceptance
//   flush           abort current op, back to IDLE, no done
//   stall           hold IF/ID/EX
//   busy            op in flight (PREP/CALC/FIX)
//   done            one-cycle result-valid pulse
//   result          final result, held until next op completes
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W2 = 2 * XLEN;

  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic [2:0]       f3_l;
  logic             w_l;
  logic [XLEN-1:0]  a_raw, b_raw, opnd;
  logic [W2-1:0]    acc, acc_nxt;
  logic             neg_q, neg_r;
  logic             qbit;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  // ---------------- operand preparation (evaluated in PREP) ----------------
  logic            a_sgn, b_sgn, na, nb, is_div, is_rem, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, ma, mb, min_val, spec_res;

  always_comb begin
    is_div  = f3_l[2];
    is_rem  = f3_l[2] & f3_l[1];
    a_sgn   = (f3_l == F3_MULH) | (f3_l == F3_MULHSU) | (f3_l == F3_DIV) | (f3_l == F3_REM);
    b_sgn   = (f3_l == F3_MULH) | (f3_l == F3_DIV) | (f3_l == F3_REM);
    a_ext   = a_raw;
    b_ext   = b_raw;
    if (w_l) begin
      a_ext = a_sgn ? sext32(a_raw[31:0]) : {{(XLEN-32){1'b0}}, a_raw[31:0]};
      b_ext = b_sgn ? sext32(b_raw[31:0]) : {{(XLEN-32){1'b0}}, b_raw[31:0]};
    end
    na      = a_sgn & a_ext[XLEN-1];
    nb      = b_sgn & b_ext[XLEN-1];
    ma      = na ? -a_ext : a_ext;
    mb      = nb ? -b_ext : b_ext;
    min_val = w_l ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = is_div & (b_ext == '0);
    ovf     = is_div & ~f3_l[0] & (a_ext == min_val) & (b_ext == '1);
    if (div0)
      spec_res = is_rem ? (w_l ? sext32(a_raw[31:0]) : a_raw) : '1;
    else
      spec_res = is_rem ? '0 : min_val;
  end

  // ---------------- sign fix-up and result select (evaluated in FIX) -------
  logic [W2-1:0]   prod, prod_s;
  logic [XLEN-1:0] q, qs, r, rs, tmp, fix_res;

  always_comb begin
    // a W multiply runs only 32 steps, so its 64-bit product sits 32 bits
    // below the top of the accumulator
    prod    = w_l ? {{(W2-64){1'b0}}, acc[(XLEN-32) +: 64]} : acc;
    prod_s  = neg_q ? -prod : prod;
    q       = w_l ? {{(XLEN-32){1'b0}}, acc[31:0]} : acc[XLEN-1:0];
    qs      = neg_q ? -q : q;
    r       = acc[W2-1:XLEN];
    rs      = neg_r ? -r : r;
    if (is_div)
      tmp = is_rem ? rs : qs;
    else if (f3_l == F3_MUL)
      tmp = prod_s[XLEN-1:0];
    else
      tmp = prod_s[W2-1:XLEN];
    fix_res = w_l ? sext32(tmp[31:0]) : tmp;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (f3_l[2]),
    .acc_nxt  (acc_nxt),
    .qbit     (qbit)
  );

  assign stall = busy | (start & ((state == S_IDLE) | (state == S_DONE)));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      cnt_last <= '0;
      f3_l     <= '0;
      w_l      <= 1'b0;
      a_raw    <= '0;
      b_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // the high-half multiplies have no W form: fold them onto MULW
            f3_l  <= (word & ~func3[2]) ? F3_MUL : func3;
            w_l   <= word;
            a_raw <= src1;
            b_raw <= src2;
            busy  <= 1'b1;
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          cnt      <= '0;
          cnt_last <= w_l ? CNT_W'(31) : CNT_W'(XLEN-1);
          neg_q    <= na ^ nb;
          neg_r    <= na;
          if (div0 | ovf) begin
            result <= spec_res;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            opnd <= is_div ? mb : ma;
            // W divide: left-align the 32-bit dividend so 32 steps consume it
            if (is_div)
              acc <= w_l ? {{XLEN{1'b0}}, ma[31:0], {(XLEN-32){1'b0}}} : {{XLEN{1'b0}}, ma};
            else
              acc <= {{XLEN{1'b0}}, mb};
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [63:0] result;

  int passed = 0;
  int total  = 0;

  muldiv_sequencer #(.XLEN(64), .CNT_W(7)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .word   (word),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // called just after a rising edge; the next edge accepts the op (cycle 0)
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    func3 = f; word = w; src1 = a; src2 = b; start = 1'b1;
    #1;
    chk({tag, "_stall_c0"}, {63'b0, stall}, 64'd1);
  endtask

  // counts cycles after acceptance until done; scrambles inputs meanwhile
  task automatic wait_done(input int exp_lat, input logic [63:0] exp_res, input string tag);
    int got = -1;
    int stall_low = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      src1 = {$urandom, $urandom};
      src2 = {$urandom, $urandom};
      func3 = 3'($urandom);
      word = 1'($urandom);
      if (done) begin got = c; break; end
      if (!stall) stall_low++;
    end
    chk({tag, "_lat"}, 64'(got), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_stall_busy"}, 64'(stall_low), 64'd0);
    chk({tag, "_stall_done"}, {63'b0, stall}, 64'd0);
  endtask

  task automatic no_done_for(input int n, input string tag);
    int seen = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk({tag, "_nodone"}, 64'(seen), 64'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // multiplies
    issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul");
    wait_done(67, 64'hFFFF_FFFF_FFFF_FFEB, "mul");
    issue(3'b011, 1'b0, '1, '1, "mulhu");
    wait_done(67, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
    issue(3'b001, 1'b0, '1, '1, "mulh");
    wait_done(67, 64'h0, "mulh");
    issue(3'b000, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'h1111_2222_0000_0002, "mulw");
    wait_done(35, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");

    // signed overflow in W divide/remainder
    issue(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divw_ovf");
    wait_done(2, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
    issue(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "remw_ovf");
    wait_done(2, 64'h0, "remw_ovf");

    // signed 64-bit divide
    issue(3'b100, 1'b0, -64'sd20, 64'd6, "div");
    wait_done(67, 64'hFFFF_FFFF_FFFF_FFFD, "div");
    issue(3'b110, 1'b0, -64'sd20, 64'd6, "rem");
    wait_done(67, 64'hFFFF_FFFF_FFFF_FFFE, "rem");

    // W divide with junk upper bits
    issue(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, "divw");
    wait_done(35, 64'hFFFF_FFFF_FFFF_FFFD, "divw");

    // divide by zero
    issue(3'b101, 1'b0, 64'd100, 64'd0, "divu0");
    wait_done(2, 64'hFFFF_FFFF_FFFF_FFFF, "divu0");
    issue(3'b111, 1'b0, 64'd100, 64'd0, "remu0");
    wait_done(2, 64'd100, "remu0");

    // flush at cycle 30 of a 64-bit divide
    issue(3'b100, 1'b0, 64'd1000, 64'd7, "flush");
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_done", {63'b0, done}, 64'd0);
    no_done_for(80, "flush");
    chk("flush_result", result, 64'd100);

    // flush beats start in IDLE
    func3 = 3'b101; word = 1'b0; src1 = 64'd5; src2 = 64'd0;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'b0, busy}, 64'd0);
    no_done_for(10, "flush_start");
    chk("flush_start_result", result, 64'd100);

    // back-to-back: new op issued during the DONE cycle
    issue(3'b101, 1'b1, 64'd17, 64'd5, "divuw");
    wait_done(35, 64'd3, "divuw");
    issue(3'b111, 1'b1, 64'd17, 64'd5, "remuw_b2b");
    wait_done(35, 64'd2, "remuw_b2b");

    // async reset in the middle of CALC
    issue(3'b100, 1'b0, 64'd1000, 64'd7, "rst_mid");
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stall", {63'b0, stall}, 64'd0);
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_done", {63'b0, done}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;
    no_done_for(80, "rst_mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
